pipe_stage_seq: RTL and testbench
=================================

Name: pipe_stage_seq

Overview:
- Parametrised fp16 pipeline stage. Per channel it computes scale = (a + d) - b*c and keeps a running per-channel accumulator of scale.
- An internal sequencer walks NUM_STAGES stages. Each stage ends after a runtime-programmable number of accepted beats. Selected stages clear the accumulator when they begin.
- It sits between the operand fetch stage and the downstream scale/accumulate consumers.
- Compared with the fixed free-running-step version, it adds a valid/ready input handshake, a start/finished protocol, a configurable channel count and stage count, and a configurable clear mask.

Parameters:
- WIDTH, 16, operand width. Only fp16 is supported; uses new_fp16_add and new_fp16_mul.
- CH, 3, number of parallel channels.
- STEP_W, 8, width of the per-stage beat counter and of each boundary entry.
- NUM_STAGES, 8, number of sequencer stages.
- MODE_STAGES, 2, mode is asserted while stage < MODE_STAGES.
- CLR_MASK, 8'b0111_0010, bit s set means the accumulator is cleared on the first beat of stage s. Width is NUM_STAGES.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset: asynchronous, active-high.
- start, input, 1, pulse that begins a run; accepted in IDLE or DONE.
- cfg_boundary, input, NUM_STAGES x STEP_W, last beat index of stage s (stage s holds cfg_boundary[s]+1 beats); sampled every beat.
- in_valid, input, 1, operands valid.
- in_ready, output, 1, block accepts operands.
- op_a, op_b, op_c, op_d, input, CH x WIDTH each, fp16 operands per channel.
- out_valid, output, 1, scale and acc updated this cycle.
- scale, output, CH x WIDTH, registered (a+d) - b*c.
- acc, output, CH x WIDTH, registered accumulator.
- stage, output, $clog2(NUM_STAGES+1), current stage index.
- mode, output, 1, (state==RUN) and (stage < MODE_STAGES).
- busy, output, 1, state==RUN.
- finished, output, 1, state==DONE.

Behaviour:
- Reset values: state=IDLE, step=0, stage=0, out_valid=0, scale=0, acc=0, in_ready=0, busy=0, finished=0, mode=0.
- FSM states:
  - IDLE: on start go to RUN; step=0, stage=0, acc=0.
  - RUN: in_ready=1. A beat is accepted when in_valid and in_ready are both high.
  - DONE: in_ready=0, finished=1. On start, restart exactly as from IDLE (acc cleared).
- start asserted while in RUN is ignored.
- Per accepted beat:
  - Datapath is combinational: s = fp_sub(fp_add(a,d), fp_mul(b,c)). Subtraction is implemented by flipping the sign bit of the product.
  - Next cycle: scale<=s and out_valid<=1.
  - acc<=s if (step==0 and CLR_MASK[stage]), else acc<=fp_add(acc,s).
- Latency: exactly 1 cycle from acceptance to out_valid. out_valid is high for one cycle per beat. The output has no backpressure.
- Step and stage on an accepted beat:
  - If step==cfg_boundary[stage]: step<=0 and stage<=stage+1.
  - If that stage was NUM_STAGES-1: stage<=NUM_STAGES and state<=DONE.
  - Otherwise step<=step+1.
- Cycles with no accepted beat: step, stage, acc and scale hold; out_valid=0.
- cfg_boundary[s]=0 gives a one-beat stage. cfg_boundary[s]=2^STEP_W-1 gives a 2^STEP_W-beat stage with no wrap: the boundary compare fires before the counter overflows.
- The final beat's result appears in the same cycle finished rises: out_valid=1 and finished=1 together.
- A beat at a clear stage's step 0 discards the old acc. There is no separate clear cycle and no bubble.
- Reset mid-run: all state returns to reset values immediately. Partial accumulations are lost.
- fp16 rounding, NaN and inf behaviour are inherited from new_fp16_add and new_fp16_mul, and channels are fully independent.

Test Plan:
1. Reset check: assert rst with start=in_valid=1 → in_ready=0, out_valid=0, acc=0, stage=0, finished=0. After release, with no start, the block stays in IDLE.
2. Single beat, all channels:
   - Stimulus: start, then a=0x3C00, d=0x4000, b=0x3C00, c=0x3800.
   - Next cycle: out_valid=1, scale=0x4100 (2.5), acc=0x4100, mode=1, stage=0.
3. Accumulate and clear:
   - Stimulus: cfg_boundary[0]=1, cfg_boundary[1]=0, each beat scale=0x3C00 (a=1, d=0, b=0, c=0).
   - acc: 0x3C00, 0x4000 in stage 0; then 0x3C00 in stage 1 (CLR_MASK[1]=1); then stage 2 (mask 0) gives 0x4000.
   - mode drops when stage reaches 2.
4. Handshake gaps: toggle in_valid 1,0,0,1 → step advances only on valid beats, acc holds during gaps, out_valid pulses twice.
5. Completion and restart:
   - All cfg_boundary=0, 8 continuous beats → finished=1 in the cycle after the 8th beat, stage=8, in_ready=0.
   - Further in_valid is ignored.
   - start → RUN, acc=0, stage=0.
6. Reset mid-run at stage 3 with acc≠0 → all outputs return to reset values on the same edge. A following start runs normally from stage 0.

Source files
------------

// File: rtl/pipe_stage_seq.sv
// fp16 pipeline stage: per-channel scale = (a + d) - b*c with a running accumulator,
// stepped by a beat-counting stage sequencer with per-stage accumulator clear.
module pipe_stage_seq #(
  parameter int unsigned           WIDTH       = 16,
  parameter int unsigned           CH          = 3,
  parameter int unsigned           STEP_W      = 8,
  parameter int unsigned           NUM_STAGES  = 8,
  parameter int unsigned           MODE_STAGES = 2,
  parameter logic [NUM_STAGES-1:0] CLR_MASK    = 8'b0111_0010
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [NUM_STAGES*STEP_W-1:0]   cfg_boundary,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [CH*WIDTH-1:0]            op_a,
  input  logic [CH*WIDTH-1:0]            op_b,
  input  logic [CH*WIDTH-1:0]            op_c,
  input  logic [CH*WIDTH-1:0]            op_d,
  output logic                           out_valid,
  output logic [CH*WIDTH-1:0]            scale,
  output logic [CH*WIDTH-1:0]            acc,
  output logic [$clog2(NUM_STAGES+1)-1:0] stage,
  output logic                           mode,
  output logic                           busy,
  output logic                           finished
);
  localparam int unsigned SG_W = $clog2(NUM_STAGES+1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Subnormals flush to zero, results truncate toward zero, exact cancellation gives +0.
  function automatic logic [15:0] new_fp16_add(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] p, q, m, r;
    logic [14:0] mp, mq;
    logic [4:0]  dexp;
    logic [6:0]  e;
    r = '0;
    if (x[14:10] == 5'd31) r = x;
    else if (y[14:10] == 5'd31) r = y;
    else if (x[14:10] == 5'd0 && y[14:10] == 5'd0) r = {x[15] & y[15], 15'b0};
    else if (x[14:10] == 5'd0) r = y;
    else if (y[14:10] == 5'd0) r = x;
    else begin
      if (x[14:0] >= y[14:0]) begin p = x; q = y; end
      else begin p = y; q = x; end
      dexp = p[14:10] - q[14:10];
      mp   = {1'b1, p[9:0], 4'b0};
      mq   = {1'b1, q[9:0], 4'b0} >> dexp;
      e    = 7'(p[14:10]);
      if (p[15] == q[15]) begin
        m = {1'b0, mp} + {1'b0, mq};
        if (m[15]) begin
          m = m >> 1;
          e = e + 7'd1;
        end
      end else begin
        m = {1'b0, mp} - {1'b0, mq};
        for (int unsigned i = 0; i < 15; i++) begin
          if (!m[14] && m != '0 && e > 7'd1) begin
            m = {m[14:0], 1'b0};
            e = e - 7'd1;
          end
        end
      end
      if (m == '0) r = '0;
      else if (e >= 7'd31) r = {p[15], 5'h1f, 10'h0};
      else if (!m[14]) r = {p[15], 15'b0};
      else r = {p[15], e[4:0], m[13:4]};
    end
    return r;
  endfunction

  function automatic logic [15:0] new_fp16_mul(input logic [15:0] x, input logic [15:0] y);
    logic        sgn;
    logic [21:0] prod;
    logic [6:0]  es;
    logic [9:0]  mant;
    logic [15:0] r;
    sgn = x[15] ^ y[15];
    r   = '0;
    if (x[14:10] == 5'd31) r = {sgn, x[14:0]};
    else if (y[14:10] == 5'd31) r = {sgn, y[14:0]};
    else if (x[14:10] == 5'd0 || y[14:10] == 5'd0) r = {sgn, 15'b0};
    else begin
      prod = 22'({1'b1, x[9:0]}) * 22'({1'b1, y[9:0]});
      es   = 7'(x[14:10]) + 7'(y[14:10]);
      if (prod[21]) begin
        es   = es + 7'd1;
        mant = prod[20:11];
      end else begin
        mant = prod[19:10];
      end
      if (es <= 7'd15) r = {sgn, 15'b0};
      else if (es >= 7'd46) r = {sgn, 5'h1f, 10'h0};
      else r = {sgn, 5'(es - 7'd15), mant};
    end
    return r;
  endfunction

  state_t              state, state_nxt;
  logic [STEP_W-1:0]   step, step_nxt, bnd;
  logic [SG_W-1:0]     stage_nxt;
  logic                accept, clr_here, clr_acc;
  logic [CH*WIDTH-1:0] s_all, acc_nxt;
  logic [15:0]         ta, tb, tc, td, prod, sv;

  always_comb begin
    bnd      = '0;
    clr_here = 1'b0;
    for (int unsigned s = 0; s < NUM_STAGES; s++) begin
      if (stage == SG_W'(s)) begin
        bnd      = cfg_boundary[s*STEP_W +: STEP_W];
        clr_here = CLR_MASK[s];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    stage_nxt = stage;
    clr_acc   = 1'b0;
    in_ready  = (state == RUN);
    busy      = (state == RUN);
    finished  = (state == DONE);
    mode      = (state == RUN) && (stage < SG_W'(MODE_STAGES));
    accept    = (state == RUN) && in_valid;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = RUN;
          step_nxt  = '0;
          stage_nxt = '0;
          clr_acc   = 1'b1;
        end
      end
      RUN: begin
        if (accept) begin
          // Boundary compare precedes the increment, so an all-ones boundary never wraps.
          if (step == bnd) begin
            step_nxt = '0;
            if (stage == SG_W'(NUM_STAGES-1)) begin
              stage_nxt = SG_W'(NUM_STAGES);
              state_nxt = DONE;
            end else begin
              stage_nxt = stage + 1'b1;
            end
          end else begin
            step_nxt = step + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_all   = '0;
    acc_nxt = '0;
    ta = '0; tb = '0; tc = '0; td = '0; prod = '0; sv = '0;
    for (int unsigned ch = 0; ch < CH; ch++) begin
      ta   = op_a[ch*WIDTH +: 16];
      tb   = op_b[ch*WIDTH +: 16];
      tc   = op_c[ch*WIDTH +: 16];
      td   = op_d[ch*WIDTH +: 16];
      prod = new_fp16_mul(tb, tc);
      sv   = new_fp16_add(new_fp16_add(ta, td), {~prod[15], prod[14:0]});
      s_all[ch*WIDTH +: 16]   = sv;
      acc_nxt[ch*WIDTH +: 16] = (step == '0 && clr_here) ? sv
                                : new_fp16_add(acc[ch*WIDTH +: 16], sv);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      step  <= '0;
      stage <= '0;
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
      stage <= stage_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      scale     <= '0;
      acc       <= '0;
    end else begin
      out_valid <= accept;
      if (accept) begin
        scale <= s_all;
        acc   <= acc_nxt;
      end else if (clr_acc) begin
        acc <= '0;
      end
    end
  end
endmodule

// File: tb/tb_pipe_stage_seq.sv
// Self-checking bench for pipe_stage_seq: directed scenarios plus randomized runs
// against a real-valued reference model of the sequencer and accumulator.
module tb_pipe_stage_seq;
  localparam int CH = 3;
  localparam int NS = 8;
  localparam int SW = 8;
  localparam logic [7:0] CLR = 8'b0111_0010;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [NS*SW-1:0]  cfg_boundary = '0;
  logic [CH*16-1:0]  op_a = '0, op_b = '0, op_c = '0, op_d = '0;
  logic              in_ready, out_valid, mode, busy, finished;
  logic [CH*16-1:0]  scale, acc;
  logic [3:0]        stage;

  int n_cmp = 0;
  int n_fail = 0;

  pipe_stage_seq #(.WIDTH(16), .CH(CH), .STEP_W(SW), .NUM_STAGES(NS), .MODE_STAGES(2),
                   .CLR_MASK(CLR)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_boundary(cfg_boundary),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_d(op_d),
    .out_valid(out_valid), .scale(scale), .acc(acc), .stage(stage),
    .mode(mode), .busy(busy), .finished(finished)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_fp(input real r);
    real mag;
    int  e, m;
    if (r == 0.0) return 16'h0000;
    mag = (r < 0.0) ? -r : r;
    e = 15;
    while (mag >= 2.0) begin mag = mag / 2.0; e++; end
    while (mag < 1.0) begin mag = mag * 2.0; e--; end
    m = $rtoi((mag - 1.0) * 1024.0);
    return {(r < 0.0), 5'(e), 10'(m)};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d);
    op_a = {CH{a}}; op_b = {CH{b}}; op_c = {CH{c}}; op_d = {CH{d}};
  endtask

  task automatic do_reset();
    start = 1'b0; in_valid = 1'b0; rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; in_valid = 1'b1;
    set_all(16'h3C00, 16'h0, 16'h0, 16'h0);
    repeat (2) cycle();
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (acc !== '0) begin n_fail++; $display("FAIL rst_acc got %h want 0", acc); end
    n_cmp++; if (stage !== 4'd0) begin n_fail++; $display("FAIL rst_stage got %0d want 0", stage); end
    n_cmp++; if ({finished, busy, mode} !== 3'b000) begin n_fail++; $display("FAIL rst_flags got %b want 000", {finished, busy, mode}); end
    rst = 1'b0; start = 1'b0;
    repeat (3) cycle();
    n_cmp++; if ({busy, in_ready, out_valid} !== 3'b000) begin n_fail++; $display("FAIL idle_hold got %b want 000", {busy, in_ready, out_valid}); end
    in_valid = 1'b0;
  endtask

  task automatic test_single_beat();
    do_reset();
    cfg_boundary = {NS{8'd3}};
    pulse_start();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL sb_ready got %b want 1", in_ready); end
    set_all(16'h3C00, 16'h3C00, 16'h3800, 16'h4000);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sb_out_valid got %b want 1", out_valid); end
    n_cmp++; if (scale !== {CH{16'h4100}}) begin n_fail++; $display("FAIL sb_scale got %h want %h", scale, {CH{16'h4100}}); end
    n_cmp++; if (acc !== {CH{16'h4100}}) begin n_fail++; $display("FAIL sb_acc got %h want %h", acc, {CH{16'h4100}}); end
    n_cmp++; if ({mode, stage} !== {1'b1, 4'd0}) begin n_fail++; $display("FAIL sb_mode_stage got %b/%0d want 1/0", mode, stage); end
    cycle();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sb_pulse got %b want 0", out_valid); end
  endtask

  task automatic test_accum_clear();
    logic [15:0] exp_acc [4];
    logic [3:0]  exp_stg [4];
    logic        exp_mode [4];
    exp_acc = '{16'h3C00, 16'h4000, 16'h3C00, 16'h4000};
    exp_stg = '{4'd0, 4'd1, 4'd2, 4'd3};
    exp_mode = '{1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    cfg_boundary = '0;
    cfg_boundary[0 +: SW] = 8'd1;
    pulse_start();
    set_all(16'h3C00, 16'h0000, 16'h0000, 16'h0000);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_cmp++; if (acc !== {CH{exp_acc[i]}}) begin n_fail++; $display("FAIL ac_acc%0d got %h want %h", i, acc, {CH{exp_acc[i]}}); end
      n_cmp++; if ({mode, stage} !== {exp_mode[i], exp_stg[i]}) begin n_fail++; $display("FAIL ac_stage%0d got %b/%0d want %b/%0d", i, mode, stage, exp_mode[i], exp_stg[i]); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_handshake_gaps();
    logic        vseq [4];
    logic [15:0] exp_acc [4];
    logic [3:0]  exp_stg [4];
    int          pulses = 0;
    vseq = '{1'b1, 1'b0, 1'b0, 1'b1};
    exp_acc = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h4000};
    exp_stg = '{4'd0, 4'd0, 4'd0, 4'd1};
    do_reset();
    cfg_boundary = '0;
    cfg_boundary[0 +: SW] = 8'd1;
    pulse_start();
    set_all(16'h3C00, 16'h0000, 16'h0000, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      in_valid = vseq[i];
      cycle();
      if (out_valid === 1'b1) pulses++;
      n_cmp++; if (out_valid !== vseq[i]) begin n_fail++; $display("FAIL hs_valid%0d got %b want %b", i, out_valid, vseq[i]); end
      n_cmp++; if (acc !== {CH{exp_acc[i]}}) begin n_fail++; $display("FAIL hs_acc%0d got %h want %h", i, acc, {CH{exp_acc[i]}}); end
      n_cmp++; if (stage !== exp_stg[i]) begin n_fail++; $display("FAIL hs_stage%0d got %0d want %0d", i, stage, exp_stg[i]); end
    end
    in_valid = 1'b0;
    n_cmp++; if (pulses != 2) begin n_fail++; $display("FAIL hs_pulses got %0d want 2", pulses); end
  endtask

  task automatic test_completion_restart();
    do_reset();
    cfg_boundary = '0;
    pulse_start();
    set_all(16'h3C00, 16'h0000, 16'h0000, 16'h0000);
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (i < 7) begin
        n_cmp++; if (finished !== 1'b0) begin n_fail++; $display("FAIL cr_early_fin%0d got %b want 0", i, finished); end
      end
    end
    n_cmp++; if ({out_valid, finished, in_ready, busy} !== 4'b1100) begin n_fail++; $display("FAIL cr_done_flags got %b want 1100", {out_valid, finished, in_ready, busy}); end
    n_cmp++; if (stage !== 4'd8) begin n_fail++; $display("FAIL cr_stage got %0d want 8", stage); end
    n_cmp++; if (acc !== {CH{16'h4000}}) begin n_fail++; $display("FAIL cr_acc got %h want %h", acc, {CH{16'h4000}}); end
    repeat (2) cycle();
    n_cmp++; if ({out_valid, stage} !== {1'b0, 4'd8}) begin n_fail++; $display("FAIL cr_ignore got %b/%0d want 0/8", out_valid, stage); end
    n_cmp++; if (acc !== {CH{16'h4000}}) begin n_fail++; $display("FAIL cr_acc_hold got %h want %h", acc, {CH{16'h4000}}); end
    in_valid = 1'b0;
    pulse_start();
    n_cmp++; if ({busy, finished, stage} !== {1'b1, 1'b0, 4'd0}) begin n_fail++; $display("FAIL cr_restart got %b%b/%0d want 10/0", busy, finished, stage); end
    n_cmp++; if (acc !== '0) begin n_fail++; $display("FAIL cr_restart_acc got %h want 0", acc); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    cfg_boundary = '0;
    pulse_start();
    set_all(16'h3C00, 16'h0000, 16'h0000, 16'h0000);
    in_valid = 1'b1;
    repeat (3) cycle();
    in_valid = 1'b0;
    n_cmp++; if ({stage, acc} !== {4'd3, {CH{16'h4000}}}) begin n_fail++; $display("FAIL mr_pre got %0d/%h want 3/%h", stage, acc, {CH{16'h4000}}); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({out_valid, busy, in_ready, finished, mode} !== 5'b0) begin n_fail++; $display("FAIL mr_flags got %b want 00000", {out_valid, busy, in_ready, finished, mode}); end
    n_cmp++; if ({stage, acc, scale} !== '0) begin n_fail++; $display("FAIL mr_state got %0d/%h/%h want 0", stage, acc, scale); end
    rst = 1'b0;
    cycle();
    pulse_start();
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    n_cmp++; if ({out_valid, stage, acc} !== {1'b1, 4'd1, {CH{16'h3C00}}}) begin n_fail++; $display("FAIL mr_rerun got %b/%0d/%h want 1/1/%h", out_valid, stage, acc, {CH{16'h3C00}}); end
  endtask

  task automatic test_random(input int runs);
    int          bnd [NS];
    int          va [CH], vb [CH], vc [CH], vd [CH];
    real         macc [CH];
    real         s;
    logic [15:0] exp_sc [CH], exp_ac [CH];
    int          m_stage, m_beats;
    bit          m_run, took;
    for (int r = 0; r < runs; r++) begin
      do_reset();
      for (int k = 0; k < NS; k++) begin
        bnd[k] = int'($urandom_range(0, 2));
        cfg_boundary[k*SW +: SW] = 8'(bnd[k]);
      end
      pulse_start();
      n_cmp++; if ({busy, acc} !== {1'b1, {(CH*16){1'b0}}}) begin n_fail++; $display("FAIL rnd%0d_start got %b/%h want 1/0", r, busy, acc); end
      m_run = 1'b1; m_stage = 0; m_beats = 0;
      for (int ch = 0; ch < CH; ch++) macc[ch] = 0.0;
      for (int cyc = 0; cyc < 200 && m_run; cyc++) begin
        in_valid = ($urandom_range(0, 3) != 0);
        for (int ch = 0; ch < CH; ch++) begin
          va[ch] = int'($urandom_range(0, 8)) - 4;
          vb[ch] = int'($urandom_range(0, 8)) - 4;
          vc[ch] = int'($urandom_range(0, 8)) - 4;
          vd[ch] = int'($urandom_range(0, 8)) - 4;
          op_a[ch*16 +: 16] = to_fp(real'(va[ch]));
          op_b[ch*16 +: 16] = to_fp(real'(vb[ch]));
          op_c[ch*16 +: 16] = to_fp(real'(vc[ch]));
          op_d[ch*16 +: 16] = to_fp(real'(vd[ch]));
        end
        took = in_valid;
        if (took) begin
          for (int ch = 0; ch < CH; ch++) begin
            s = real'(va[ch] + vd[ch] - vb[ch] * vc[ch]);
            if (m_beats == 0 && CLR[m_stage]) macc[ch] = s;
            else macc[ch] = macc[ch] + s;
            exp_sc[ch] = to_fp(s);
            exp_ac[ch] = to_fp(macc[ch]);
          end
          m_beats++;
          if (m_beats == bnd[m_stage] + 1) begin
            m_beats = 0;
            m_stage++;
            if (m_stage == NS) m_run = 1'b0;
          end
        end
        cycle();
        n_cmp++; if (out_valid !== took) begin n_fail++; $display("FAIL rnd%0d_valid c%0d got %b want %b", r, cyc, out_valid, took); end
        if (took) begin
          for (int ch = 0; ch < CH; ch++) begin
            n_cmp++; if (scale[ch*16 +: 16] !== exp_sc[ch]) begin n_fail++; $display("FAIL rnd%0d_scale c%0d ch%0d got %h want %h", r, cyc, ch, scale[ch*16 +: 16], exp_sc[ch]); end
            n_cmp++; if (acc[ch*16 +: 16] !== exp_ac[ch]) begin n_fail++; $display("FAIL rnd%0d_acc c%0d ch%0d got %h want %h", r, cyc, ch, acc[ch*16 +: 16], exp_ac[ch]); end
          end
        end
        n_cmp++; if (stage !== 4'(m_stage)) begin n_fail++; $display("FAIL rnd%0d_stage c%0d got %0d want %0d", r, cyc, stage, m_stage); end
        n_cmp++; if ({finished, mode} !== {!m_run, m_run && m_stage < 2}) begin n_fail++; $display("FAIL rnd%0d_flags c%0d got %b want %b", r, cyc, {finished, mode}, {!m_run, m_run && m_stage < 2}); end
      end
      in_valid = 1'b0;
      n_cmp++; if (m_run) begin n_fail++; $display("FAIL rnd%0d_timeout got stage %0d want %0d", r, stage, NS); end
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_accum_clear();
    test_handshake_gaps();
    test_completion_restart();
    test_reset_mid_run();
    test_random(6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
